// File: rtl/bram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port BRAM with one-cycle read latency.
// Tracks the owner of the in-flight access and keeps each port's last read word stable.
module bram_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_L = 4,
  localparam int DATA_W = DATA_L * 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [DATA_L-1:0] p0_sel,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rdata,

  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic [DATA_L-1:0] p1_sel,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rdata,

  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data_w,
  output logic [DATA_L-1:0] bram_sel,
  output logic              bram_en,
  input  logic [DATA_W-1:0] bram_data_r
);

  logic              last_grant;
  logic              pending_valid;
  logic              pending_port;
  logic [DATA_W-1:0] hold0;
  logic [DATA_W-1:0] hold1;
  logic              grant0;
  logic              grant1;

  // Under contention the port that did not win last time goes next.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (p0_req_valid && p1_req_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = p0_req_valid;
        grant1 = p1_req_valid;
      end
    end
  end

  assign p0_req_ready = grant0;
  assign p1_req_ready = grant1;
  assign bram_en      = grant0 | grant1;

  always_comb begin
    bram_addr   = p0_addr;
    bram_data_w = p0_wdata;
    bram_sel    = p0_sel;
    if (grant1) begin
      bram_addr   = p1_addr;
      bram_data_w = p1_wdata;
      bram_sel    = p1_sel;
    end
  end

  // Reset in the response cycle swallows the response of the preceding grant.
  assign p0_rsp_valid = pending_valid && !pending_port && !rst;
  assign p1_rsp_valid = pending_valid &&  pending_port && !rst;

  assign p0_rdata = p0_rsp_valid ? bram_data_r : hold0;
  assign p1_rdata = p1_rsp_valid ? bram_data_r : hold1;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant    <= 1'b1;
      pending_valid <= 1'b0;
      pending_port  <= 1'b0;
      hold0         <= '0;
      hold1         <= '0;
    end else begin
      if (grant0) begin
        last_grant <= 1'b0;
      end else if (grant1) begin
        last_grant <= 1'b1;
      end
      pending_valid <= grant0 | grant1;
      pending_port  <= grant1;
      if (p0_rsp_valid) begin
        hold0 <= bram_data_r;
      end
      if (p1_rsp_valid) begin
        hold1 <= bram_data_r;
      end
    end
  end

endmodule
